mmio_uart_rx: RTL and testbench
===============================

// Module: mmio_uart_rx
// PURPOSE
//  Memory-mapped UART receiver: deserialises 8N1 frames on UART_RXD and exposes data/status to the CPU load path.
//  Sits beside the switch input mux in the data-memory read path, between RAM/switch read data and the write-back mux.
//  Receive-side counterpart of the CPU's store-to-output path: the core polls status, then loads and pops the byte.
// PARAMETERS
//  CLK_HZ     50000000  clk frequency in Hz
//  BAUD       9600      line rate; OSR tick every CLK_HZ/(BAUD*16) clocks (integer division)
//  DATA_ADDR  8'hFE     load address returning received byte
//  STAT_ADDR  8'hFD     load address returning status byte
// PORTS
//  clk      in   1  system clock (CLOCK_50)
//  rst      in   1  asynchronous reset, active-high
//  rx       in   1  serial line, idle high, asynchronous to clk
//  Address  in   8  ALU result / data address
//  MemData  in   8  upstream read data (RAM / switch mux)
//  rd_pop   in   1  one-clk strobe: CPU consumed the addressed register
//  RegData  out  8  read data to write-back mux
//  rx_valid out  1  byte available (status bit 0)
// BEHAVIOUR
//  - Reset: sync FFs=1, FSM=IDLE, counters=0, data=0, valid/frame_err/overrun=0; RegData follows mux comb.
//  - rx through 2-FF synchroniser; all decisions on the synchronised value rx_s.
//  - Tick gen: counter 0..DIV-1, DIV=CLK_HZ/(BAUD*16); tick pulse 1 clk at wrap; free-running.
//  - FSM (advances on tick only):
//    IDLE : rx_s==0 -> START, tick count=0
//    START: at tick 7 (mid start bit) rx_s==0 -> DATA, bit=0; rx_s==1 -> IDLE (glitch rejected, no flags)
//    DATA : every 16 ticks sample rx_s into shift reg, LSB first; after bit 7 -> STOP
//    STOP : after 16 ticks sample; 1 -> commit byte; 0 -> frame_err=1, byte discarded; both -> IDLE
//  - Commit: data<=shift, valid<=1 in same clk as STOP sample. If valid already 1 and no pop in that clk:
//    data overwritten, overrun=1.
//  - Pop: rd_pop & Address==DATA_ADDR -> valid<=0. Pop with valid==0 ignored.
//    rd_pop & Address==STAT_ADDR -> frame_err<=0, overrun<=0 (valid untouched).
//  - Same-clk pop(DATA) + commit: commit wins, valid stays 1, new byte visible, overrun not set.
//  - Same-clk clear(STAT) + new error: new error wins (flag stays 1).
//  - Read mux (comb, zero latency): DATA_ADDR -> data (8'h00 when valid==0);
//    STAT_ADDR -> {5'b0, overrun, frame_err, valid}; else MemData.
//  - Reset mid-frame: aborts immediately, no partial byte committed; receiver waits for next falling edge.
//  - rx held low (break): one frame_err, then stays in IDLE until rx_s returns high, then re-arms.
// CONFIGURATION
//  UART_RX_FIFO_EN defined: 4-entry FIFO replaces holding register; valid = !empty;
//    DATA_ADDR reads head; pop advances head; commit when full -> byte dropped, overrun=1,
//    FIFO contents preserved; simultaneous pop+commit when full -> both accepted, no overrun;
//    status bit 3 = full.
//  Undefined: single holding register with overwrite-on-overrun as above; status bit 3 = 0.
// TESTING (bench params CLK_HZ=1600000, BAUD=100000 -> DIV=1, 16 clk/bit)
//  1 send 0xA5 8N1 -> within 160 clk of start edge valid=1; read FE=8'hA5; read FD=8'h01;
//    pop FE -> read FD=8'h00
//  2 0-pulse of 4 clk on idle line -> FSM back to IDLE, valid=0, FD=8'h00
//  3 frame 0x3C with stop bit=0 -> valid=0, FD=8'h02; pop FD -> FD=8'h00
//  4 send 0x11 then 0x22 without pop -> FE=8'h22, FD=8'h05 (no FIFO);
//    with UART_RX_FIFO_EN send 5 bytes -> FD=8'h0D, pops return 11,22,33,44
//  5 assert rst during data bit 4 of 0x5A, release, send 0x81 -> only 0x81 received, no flags
//  6 Address=8'h10, MemData=8'h77 -> RegData=8'h77 in same cycle regardless of receiver state

Source files
------------

// File: rtl/mmio_uart_rx.sv
// Memory-mapped 8N1 UART receiver with data/status registers on the CPU load path.
// Optional UART_RX_FIFO_EN replaces the single holding register with a 4-entry FIFO.
module mmio_uart_rx #(
    parameter int         CLK_HZ    = 50000000,
    parameter int         BAUD      = 9600,
    parameter logic [7:0] DATA_ADDR = 8'hFE,
    parameter logic [7:0] STAT_ADDR = 8'hFD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [7:0] Address,
    input  logic [7:0] MemData,
    input  logic       rd_pop,
    output logic [7:0] RegData,
    output logic       rx_valid
);
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    // state   | meaning
    // S_IDLE  | waiting for a falling edge on rx_s
    // S_START | counting to mid start bit to confirm it
    // S_DATA  | sampling 8 data bits, LSB first
    // S_STOP  | sampling stop bit, commit or flag frame error
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic       sync1_q, rx_s_q;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       wait_hi_q, wait_hi_d;
    logic       tick, commit, stop_err;
    logic       pop_data, pop_stat;
    logic       fe_q, fe_d, ov_q, ov_d;
    logic       valid, full;
    logic [7:0] head;

    assign tick     = (div_q == DW'(DIV - 1));
    assign div_d    = tick ? '0 : div_q + 1'b1;
    assign pop_data = rd_pop && (Address == DATA_ADDR);
    assign pop_stat = rd_pop && (Address == STAT_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            div_q     <= '0;
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            wait_hi_q <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            div_q     <= div_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wait_hi_q <= wait_hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wait_hi_d = wait_hi_q;
        commit    = 1'b0;
        stop_err  = 1'b0;
        // After a frame error the line must go idle before a new start is accepted (break handling).
        if (wait_hi_q && rx_s_q) wait_hi_d = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q && !wait_hi_q) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end
                S_START: begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                S_DATA: begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                S_STOP: begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d  = '0;
                        state_d = S_IDLE;
                        if (rx_s_q) begin
                            commit = 1'b1;
                        end else begin
                            stop_err  = 1'b1;
                            wait_hi_d = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] cnt_q;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 3'd4);
    assign valid   = (cnt_q != 3'd0);
    assign head    = mem_q[rd_q];
    assign do_pop  = pop_data && valid;
    // A pop in the same clock frees the slot, so a commit into a full FIFO is still accepted.
    assign do_push = commit && (!full || do_pop);
    assign ov_d    = (commit && full && !do_pop) ? 1'b1 : (pop_stat ? 1'b0 : ov_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= shift_q;
            wr_q  <= wr_q + {1'b0, do_push};
            rd_q  <= rd_q + {1'b0, do_pop};
            cnt_q <= cnt_q + {2'b0, do_push} - {2'b0, do_pop};
        end
    end
`else
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign full    = 1'b0;
    assign valid   = valid_q;
    assign head    = data_q;
    assign data_d  = commit ? shift_q : data_q;
    assign valid_d = commit ? 1'b1 : (pop_data ? 1'b0 : valid_q);
    assign ov_d    = (commit && valid_q && !pop_data) ? 1'b1 : (pop_stat ? 1'b0 : ov_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

    assign fe_d = stop_err ? 1'b1 : (pop_stat ? 1'b0 : fe_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            fe_q <= fe_d;
            ov_q <= ov_d;
        end
    end

    always_comb begin
        RegData = MemData;
        if (Address == DATA_ADDR)      RegData = valid ? head : 8'h00;
        else if (Address == STAT_ADDR) RegData = {4'b0, full, ov_q, fe_q, valid};
    end

    assign rx_valid = valid;
endmodule

// File: tb/tb_mmio_uart_rx.sv
// Bench for mmio_uart_rx: directed table/sequences plus random traffic against a queue model.
// Define UART_RX_FIFO_EN for both bench and RTL to check the FIFO build.
module tb_mmio_uart_rx;
    localparam logic [7:0] FE = 8'hFE;
    localparam logic [7:0] FD = 8'hFD;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, rx, rd_pop;
    logic [7:0] Address, MemData, RegData;
    logic       rx_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic       m_fe, m_ov;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] mem;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[6];

    mmio_uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .DATA_ADDR(8'hFE), .STAT_ADDR(8'hFD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .Address(Address), .MemData(MemData),
        .rd_pop(rd_pop), .RegData(RegData), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_chk(input logic [7:0] addr, input logic [7:0] exp, input string name);
        Address = addr;
        #1;
        chk(name, RegData, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop(input logic [7:0] addr);
        Address = addr;
        rd_pop  = 1'b1;
        @(posedge clk);
        #1;
        rd_pop = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int from, input int to);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = from; i < to; i++) begin
            rx = f[i / 16];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        drive_frame(b, stop, 0, 160);
        rx = 1'b1;
        idle(6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic m_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_fe = 1'b1;
        else if (mq.size() == DEPTH) begin
            m_ov = 1'b1;
            if (DEPTH == 1) mq[0] = b;
        end else mq.push_back(b);
    endtask

    task automatic check_model(input string name);
        logic [7:0] efe, efd;
        efe = (mq.size() != 0) ? mq[0] : 8'h00;
        efd = {4'b0, (DEPTH == 4) && (mq.size() == 4), m_ov, m_fe, mq.size() != 0};
        read_chk(FE, efe, {name, "_fe"});
        read_chk(FD, efd, {name, "_fd"});
        chk({name, "_valid"}, {7'b0, rx_valid}, {7'b0, mq.size() != 0});
    endtask

    initial begin
        tbl[0] = '{8'h10, 8'h77, 8'h77};
        tbl[1] = '{FE,    8'h33, 8'hA5};
        tbl[2] = '{FD,    8'h44, 8'h01};
        tbl[3] = '{8'h00, 8'hFF, 8'hFF};
        tbl[4] = '{8'hFC, 8'h3C, 8'h3C};
        tbl[5] = '{8'hFF, 8'h12, 8'h12};

        rst = 1'b1; rx = 1'b1; Address = 8'h00; MemData = 8'h00; rd_pop = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        read_chk(FE, 8'h00, "rst_fe");
        read_chk(FD, 8'h00, "rst_fd");
        chk("rst_valid", {7'b0, rx_valid}, 8'h00);
        MemData = 8'h77;
        read_chk(8'h10, 8'h77, "rst_pass");

        // byte arrives between 150 and 160 clocks after the start edge
        drive_frame(8'hA5, 1'b1, 0, 150);
        chk("a5_early_valid", {7'b0, rx_valid}, 8'h00);
        drive_frame(8'hA5, 1'b1, 150, 160);
        rx = 1'b1;
        chk("a5_valid", {7'b0, rx_valid}, 8'h01);
        for (int i = 0; i < 6; i++) begin
            MemData = tbl[i].mem;
            read_chk(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
        end
        pop(FE);
        read_chk(FD, 8'h00, "a5_pop_fd");
        read_chk(FE, 8'h00, "a5_pop_fe");
        pop(FE);
        read_chk(FD, 8'h00, "empty_pop_fd");

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        read_chk(FD, 8'h00, "glitch_fd");
        send(8'h96, 1'b1);
        read_chk(FE, 8'h96, "post_glitch_fe");
        pop(FE);

        send(8'h3C, 1'b0);
        chk("ferr_valid", {7'b0, rx_valid}, 8'h00);
        read_chk(FD, 8'h02, "ferr_fd");
        pop(FD);
        read_chk(FD, 8'h00, "ferr_clr_fd");

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send(8'(i * 8'h11), 1'b1);
        read_chk(FD, 8'h0D, "ovr_fd");
        pop(FD);
        read_chk(FD, 8'h09, "ovr_clr_fd");
        for (int i = 1; i <= 4; i++) begin
            read_chk(FE, 8'(i * 8'h11), $sformatf("fifo_pop%0d", i));
            pop(FE);
        end
`else
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        read_chk(FE, 8'h22, "ovr_fe");
        read_chk(FD, 8'h05, "ovr_fd");
        pop(FD);
        pop(FE);
`endif
        read_chk(FD, 8'h00, "ovr_done_fd");

        drive_frame(8'h5A, 1'b1, 0, 16 + 4 * 16 + 8);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        rx  = 1'b1;
        idle(20);
        read_chk(FD, 8'h00, "midrst_fd");
        send(8'h81, 1'b1);
        read_chk(FE, 8'h81, "midrst_fe");
        read_chk(FD, 8'h01, "midrst_fd2");
        pop(FE);

        drive_frame(8'hC3, 1'b1, 0, 80);
        MemData = 8'h5E;
        read_chk(8'h10, 8'h5E, "pass_midframe");
        drive_frame(8'hC3, 1'b1, 80, 160);
        rx = 1'b1;
        idle(6);
        read_chk(FE, 8'hC3, "c3_fe");
        pop(FE);

        rx = 1'b0;
        idle(300);
        read_chk(FD, 8'h02, "break_fd");
        chk("break_valid", {7'b0, rx_valid}, 8'h00);
        rx = 1'b1;
        idle(20);
        send(8'h42, 1'b1);
        read_chk(FE, 8'h42, "post_break_fe");
        read_chk(FD, 8'h03, "post_break_fd");
        pop(FD);
        read_chk(FD, 8'h01, "post_break_clr");
        pop(FE);

        do_reset();
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        for (int n = 0; n < 30; n++) begin
            int unsigned r;
            logic [7:0] b, a;
            logic stop;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                b    = 8'($urandom);
                stop = ($urandom_range(0, 4) != 0);
                send(b, stop);
                m_frame(b, stop);
            end else if (r <= 8) begin
                pop(FE);
                if (mq.size() != 0) void'(mq.pop_front());
            end else begin
                pop(FD);
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            check_model($sformatf("rnd%0d", n));
            a = 8'($urandom_range(0, 8'hFC));
            MemData = 8'($urandom);
            read_chk(a, MemData, $sformatf("rnd%0d_pass", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
